// File: rtl/inst_mem_burst.sv
// Backing instruction memory that answers a block-aligned cache fill with a gap-free burst.
// A preload write port is honoured only while no fill is in progress.
module inst_mem_burst #(
   parameter int DATA_WIDTH         = 32,
   parameter int ADDR_WIDTH         = 20,
   parameter int BLOCK_OFFSET_WIDTH = 9,
   parameter int MEM_DEPTH_WIDTH    = 12,
   parameter int FIRST_WORD_LATENCY = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       req_valid,
   input  logic [ADDR_WIDTH-1:0]      req_addr,
   output logic                       resp_valid,
   output logic                       resp_last,
   output logic [DATA_WIDTH-1:0]      resp_data,
   output logic                       busy,
   input  logic                       wr_en,
   input  logic [MEM_DEPTH_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0]      wr_data
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_BURST = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam int LAT_W = (FIRST_WORD_LATENCY > 1) ? $clog2(FIRST_WORD_LATENCY) : 1;
   localparam int CNT_W = BLOCK_OFFSET_WIDTH + 1;
   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'((1 << BLOCK_OFFSET_WIDTH) - 1);
   localparam logic [CNT_W-1:0] ALL_WORDS = CNT_W'(1 << BLOCK_OFFSET_WIDTH);
   localparam logic [MEM_DEPTH_WIDTH-1:0] BLOCK_MASK = ~MEM_DEPTH_WIDTH'((1 << BLOCK_OFFSET_WIDTH) - 1);

   logic [DATA_WIDTH-1:0] mem [0:(1 << MEM_DEPTH_WIDTH)-1];

   logic [1:0]                 state_q, state_d;
   logic [LAT_W-1:0]           lat_cnt_q, lat_cnt_d;
   logic [CNT_W-1:0]           word_cnt_q, word_cnt_d;
   logic [MEM_DEPTH_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic                       resp_valid_q, resp_valid_d;
   logic                       resp_last_q, resp_last_d;
   logic                       busy_q, busy_d;
   logic [DATA_WIDTH-1:0]      resp_data_q;
   logic                       emit;
   logic                       mem_we;
   logic                       req_addr_unused;

   // Only the in-depth, block-aligned part of the request address matters.
   assign req_addr_unused = ^req_addr;

   always_comb begin
      state_d      = state_q;
      lat_cnt_d    = lat_cnt_q;
      word_cnt_d   = word_cnt_q;
      rd_addr_d    = rd_addr_q;
      resp_valid_d = 1'b0;
      resp_last_d  = 1'b0;
      emit         = 1'b0;
      mem_we       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               state_d    = S_WAIT;
               lat_cnt_d  = LAT_W'(FIRST_WORD_LATENCY - 1);
               word_cnt_d = '0;
               // Truncating the base first equals truncating base+offset, so wrap is free.
               rd_addr_d  = req_addr[MEM_DEPTH_WIDTH-1:0] & BLOCK_MASK;
            end else if (wr_en) begin
               mem_we = 1'b1;
            end
         end
         S_WAIT: begin
            if (!req_valid) begin
               state_d = S_IDLE;
            end else if (lat_cnt_q == '0) begin
               state_d = S_BURST;
               emit    = 1'b1;
            end else begin
               lat_cnt_d = lat_cnt_q - LAT_W'(1);
            end
         end
         S_BURST: begin
            if (!req_valid) begin
               state_d = S_IDLE;
            end else if (word_cnt_q == ALL_WORDS) begin
               state_d = S_DONE;
            end else begin
               emit = 1'b1;
            end
         end
         default: begin
            if (!req_valid) begin
               state_d = S_IDLE;
            end
         end
      endcase
      // rd_addr_q already points at the word being emitted; advance it for the next one.
      if (emit) begin
         resp_valid_d = 1'b1;
         resp_last_d  = (word_cnt_q == LAST_WORD);
         word_cnt_d   = word_cnt_q + CNT_W'(1);
         rd_addr_d    = rd_addr_q + MEM_DEPTH_WIDTH'(1);
      end
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         lat_cnt_q    <= '0;
         word_cnt_q   <= '0;
         rd_addr_q    <= '0;
         resp_valid_q <= 1'b0;
         resp_last_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         lat_cnt_q    <= lat_cnt_d;
         word_cnt_q   <= word_cnt_d;
         rd_addr_q    <= rd_addr_d;
         resp_valid_q <= resp_valid_d;
         resp_last_q  <= resp_last_d;
         busy_q       <= busy_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Block RAM read port; the output register holds its value between words.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_data_q <= '0;
      end else if (emit) begin
         resp_data_q <= mem[rd_addr_q];
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_last  = resp_last_q;
   assign resp_data  = resp_data_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_inst_mem_burst.sv
// Randomized and directed bench for inst_mem_burst against a transaction-timing reference model.
module tb_inst_mem_burst;

   localparam int DW = 32;
   localparam int AW = 20;
   localparam int BOW = 2;
   localparam int MW = 6;
   localparam int LAT = 3;
   localparam int B = 1 << BOW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic          resp_valid;
   logic          resp_last;
   logic [DW-1:0] resp_data;
   logic          busy;
   logic          wr_en = 1'b0;
   logic [MW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;

   int checks = 0;
   int failures = 0;

   // reference model: edge counter, accepted-request edge, shadow memory
   int            n = 0;
   bit            m_act = 0;
   bit            m_done = 0;
   int            m_acc = 0;
   logic [MW-1:0] m_base = '0;
   logic [DW-1:0] shadow [0:(1<<MW)-1];
   int            e_off = 0;
   bit            e_valid = 0;
   bit            e_last = 0;
   bit            e_busy = 0;
   logic [DW-1:0] e_data = '0;
   logic [DW-1:0] first_word;

   inst_mem_burst #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_OFFSET_WIDTH(BOW),
      .MEM_DEPTH_WIDTH(MW), .FIRST_WORD_LATENCY(LAT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
      .resp_valid(resp_valid), .resp_last(resp_last), .resp_data(resp_data),
      .busy(busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, n);
      end
   endtask

   // A request accepted at edge a yields words at edges a+LAT .. a+LAT+B-1;
   // a low req_valid anywhere in flight returns to idle; a request held past
   // the burst stays parked until it is dropped.
   task automatic model_edge();
      logic [MW-1:0] idx;
      n++;
      if (!rst_n) begin
         m_act = 0;
         m_done = 0;
      end else if (m_act || m_done) begin
         if (!req_valid) begin
            m_act = 0;
            m_done = 0;
         end else if (m_act && (n - m_acc) == LAT + B) begin
            m_act = 0;
            m_done = 1;
         end
      end else if (req_valid) begin
         m_act = 1;
         m_acc = n;
         m_base = req_addr[MW-1:0] & ~MW'(B - 1);
      end else if (wr_en) begin
         shadow[wr_addr] = wr_data;
      end
      e_off = n - m_acc - LAT;
      e_valid = m_act && e_off >= 0 && e_off < B;
      e_last = e_valid && e_off == B - 1;
      e_busy = m_act || m_done;
      idx = m_base + MW'(e_off);
      e_data = shadow[idx];
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("resp_valid", DW'(resp_valid), DW'(e_valid));
      check("resp_last", DW'(resp_last), DW'(e_last));
      check("busy", DW'(busy), DW'(e_busy));
      if (e_valid) check("resp_data", resp_data, e_data);
   endtask

   task automatic burst(input logic [AW-1:0] a, input int hold, output logic [DW-1:0] first);
      int start;
      int got_first;
      int words;
      bit seen;
      req_valid = 1'b1;
      req_addr = a;
      start = n + 1;
      got_first = -1;
      words = 0;
      seen = 0;
      first = '0;
      for (int i = 0; i < 20 && !seen; i++) begin
         step();
         if (resp_valid) begin
            words++;
            if (got_first < 0) begin
               got_first = n;
               first = resp_data;
            end
         end
         if (e_last) seen = 1;
      end
      check("burst_done", DW'(seen), DW'(1));
      check("first_latency", DW'(got_first - start), DW'(LAT));
      check("word_count", DW'(words), DW'(B));
      for (int i = 0; i < hold; i++) begin
         step();
         check("held_no_valid", DW'(resp_valid), DW'(0));
      end
      req_valid = 1'b0;
      wr_en = 1'b0;
      step();
      check("idle_after", DW'(busy), DW'(0));
   endtask

   initial begin
      for (int i = 0; i < (1 << MW); i++) shadow[i] = '0;
      repeat (3) step();
      check("reset_valid", DW'(resp_valid), DW'(0));
      check("reset_data", resp_data, '0);
      #2 rst_n = 1'b1;

      // preload everything so the model and RAM agree, then the A0..A3 block
      for (int i = 0; i < (1 << MW); i++) begin
         wr_en = 1'b1; wr_addr = MW'(i); wr_data = $urandom;
         step();
      end
      for (int i = 0; i < B; i++) begin
         wr_addr = MW'(8 + i); wr_data = DW'(32'hA0 + i);
         step();
      end
      wr_en = 1'b0;
      step();

      burst(20'h9, 0, first_word);
      check("basic_first", first_word, 32'hA0);
      burst(20'h48, 0, first_word);
      check("alias_first", first_word, 32'hA0);

      // abort after the second word
      req_valid = 1'b1; req_addr = 20'h8;
      for (int i = 0; i < 20 && !(e_valid && e_off == 1); i++) step();
      check("abort_reached", DW'(e_valid && e_off == 1), DW'(1));
      req_valid = 1'b0;
      step();
      check("abort_busy", DW'(busy), DW'(0));
      burst(20'h8, 0, first_word);
      check("after_abort_first", first_word, 32'hA0);

      // held request, then one low cycle and a fresh burst
      burst(20'h8, 5, first_word);
      burst(20'hB, 0, first_word);
      check("rearm_first", first_word, 32'hA0);

      // write with request on the same idle edge, and held through the burst
      wr_en = 1'b1; wr_addr = 6'd8; wr_data = 32'hFF;
      burst(20'h8, 0, first_word);
      burst(20'h8, 0, first_word);
      check("write_gated", first_word, 32'hA0);

      // asynchronous reset in the middle of a burst
      req_valid = 1'b1; req_addr = 20'h8;
      for (int i = 0; i < 20 && !(e_valid && e_off == 1); i++) step();
      check("reset_reached", DW'(e_valid && e_off == 1), DW'(1));
      #2 rst_n = 1'b0;
      #1;
      check("async_valid", DW'(resp_valid), DW'(0));
      check("async_last", DW'(resp_last), DW'(0));
      req_valid = 1'b0;
      step();
      #2 rst_n = 1'b1;
      step();
      burst(20'h8, 0, first_word);
      check("post_reset_first", first_word, 32'hA0);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 7) == 0) req_valid = ~req_valid;
         if ($urandom_range(0, 3) == 0) req_addr = AW'($urandom);
         wr_en = ($urandom_range(0, 2) == 0);
         wr_addr = MW'($urandom);
         wr_data = $urandom;
         step();
      end
      req_valid = 1'b0;
      wr_en = 1'b0;
      repeat (3) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
